// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader sitting in front of instruction
// memory. It accepts a byte stream over valid/ready and expects this frame:
//   count_lo, count_hi (N words, little-endian), then 4*N data bytes,
//   with each word sent least-significant byte first.
// Each assembled word is written to imem at word address 0..N-1, one
// write per word. The CPU is held (cpu_hold_o=1) until the whole image
// has landed in memory.
//
// Optional feature, enabled by defining IMEM_LOADER_CHECKSUM_EN:
//   one trailer byte follows the data bytes. It carries the XOR of all data
//   bytes. A mismatch ends the load in the error state.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   in_data_i      stream byte
//   in_valid_i     in_data_i valid
//   in_ready_o     loader can accept a byte this cycle
//   start_i        reload request, honoured only once done or in error
//   imem_we_o      instruction memory write strobe (one cycle per word)
//   imem_addr_o    word address of the write
//   imem_wdata_o   instruction word being written
//   cpu_hold_o     1 = CPU held in reset
//   load_done_o    image loaded successfully
//   load_error_o   bad header (or bad checksum)
//   words_loaded_o number of words written in the current load
//
// ADDR_WIDTH is assumed to be at most 16, because the header count is 16 bits.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  start_i,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [31:0]           imem_wdata_o,
  output logic                  cpu_hold_o,
  output logic                  load_done_o,
  output logic                  load_error_o,
  output logic [ADDR_WIDTH:0]   words_loaded_o
);

  localparam logic [2:0] CNT_LO = 3'd0;
  localparam logic [2:0] CNT_HI = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] FINISH = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] ERR    = 3'd5;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHK    = 3'd6;
  // After the data bytes the trailer byte is still to come.
  localparam logic [2:0] AFTER_DATA = CHK;
`else
  localparam logic [2:0] AFTER_DATA = FINISH;
`endif

  // Memory capacity in words. It is compared against the 16-bit header
  // count, so the width is 17 bits.
  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

  logic [2:0]            state_q, state_d;
  logic [1:0]            lane_q, lane_d;
  logic [23:0]           asm_q, asm_d;
  logic [7:0]            cnt_lo_q, cnt_lo_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   wl_q, wl_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic        xfer;
  logic [16:0] hdr_n;

  always_comb begin
    in_ready_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        CNT_LO, CNT_HI, DATA: in_ready_o = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK:                  in_ready_o = 1'b1;
`endif
        default:              in_ready_o = 1'b0;
      endcase
    end
  end

  assign xfer  = in_valid_i & in_ready_o;
  assign hdr_n = {1'b0, in_data_i, cnt_lo_q};

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    asm_d    = asm_q;
    cnt_lo_d = cnt_lo_q;
    cnt_d    = cnt_q;
    wl_d     = wl_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      CNT_LO: begin
        if (xfer) begin
          cnt_lo_d = in_data_i;
          state_d  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (xfer) begin
          cnt_d = hdr_n[15:0];
          if (hdr_n > CAP)          state_d = ERR;
          else if (hdr_n == 17'd0)  state_d = AFTER_DATA;
          else                      state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data_i;
`endif
          lane_d = lane_q + 2'd1;
          // Bytes shift in from the top, so after three bytes asm_q holds
          // {b2,b1,b0}. The fourth byte completes the word directly.
          asm_d  = {in_data_i, asm_q[23:8]};
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = wl_q[ADDR_WIDTH-1:0];
            wdata_d = {in_data_i, asm_q};
            wl_d    = wl_q + 1'b1;
            if (17'(wl_q) + 17'd1 == {1'b0, cnt_q})
              state_d = AFTER_DATA;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer)
          state_d = (in_data_i == csum_q) ? FINISH : ERR;
      end
`endif
      // One cycle here lets the final write land before the CPU is released.
      FINISH: state_d = DONE;
      DONE, ERR: begin
        if (start_i) begin
          state_d = CNT_LO;
          wl_d    = '0;
          lane_d  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = 8'd0;
`endif
        end
      end
      default: state_d = CNT_LO;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= CNT_LO;
      lane_q   <= 2'd0;
      asm_q    <= '0;
      cnt_lo_q <= '0;
      cnt_q    <= '0;
      wl_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      asm_q    <= asm_d;
      cnt_lo_q <= cnt_lo_d;
      cnt_q    <= cnt_d;
      wl_q     <= wl_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign imem_we_o      = we_q;
  assign imem_addr_o    = addr_q;
  assign imem_wdata_o   = wdata_q;
  assign words_loaded_o = wl_q;
  assign cpu_hold_o     = (state_q != DONE);
  assign load_done_o    = (state_q == DONE);
  assign load_error_o   = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          start;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .start_i(start), .imem_we_o(imem_we),
    .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata), .cpu_hold_o(cpu_hold),
    .load_done_o(load_done), .load_error_o(load_error),
    .words_loaded_o(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } wr_t;

  wr_t         sb[$];
  wr_t         mon_e;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  logic [31:0] wbuf [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every write strobe must match the oldest expected write, and it must
  // occur in the cycle right after the handshake of that word's 4th byte.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      check("we_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("wr_addr", imem_addr, mon_e.addr);
        check("wr_data", imem_wdata, mon_e.data);
        check("wr_cycle", cyc, mon_e.cyc);
        check("wr_count", words_loaded, mon_e.addr + 1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int t;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    t  = 0;
    ok = in_ready;
    while (!ok && t < 20) begin
      @(negedge clk);
      ok = in_ready;
      t++;
    end
    if (!ok) begin
      check("hs_timeout", ok, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    hs_cyc   = cyc;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("restart_ready", in_ready, 1);
    check("restart_hold", cpu_hold, 1);
    check("restart_done", load_done, 0);
    check("restart_err", load_error, 0);
    check("restart_wl", words_loaded, 0);
  endtask

  // Load n words from wbuf. Optional: a gap of gap_len idle cycles after data
  // byte gap_at (with a start pulse, which must be ignored), a reset abort
  // after data byte abort_at, or a corrupted checksum trailer.
  task automatic load_words(input int n, input int gap_at, input int gap_len,
                            input bit start_in_gap, input int abort_at,
                            input bit bad_csum);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [15:0] n16;
    wr_t         e;
    int          j;
    x   = 8'd0;
    n16 = n[15:0];
    send_byte(n16[7:0]);
    send_byte(n16[15:8]);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = wbuf[i][8*k +: 8];
        send_byte(b);
        x ^= b;
        if (k == 3) begin
          e.addr = i[AW-1:0];
          e.data = wbuf[i];
          e.cyc  = hs_cyc;
          sb.push_back(e);
        end
        j = i*4 + k + 1;
        if (j == gap_at) begin
          for (int g = 0; g < gap_len; g++) begin
            @(negedge clk);
            start = start_in_gap && (g == 0);
          end
          start = 1'b0;
        end
        if (j == abort_at) begin
          #2 rst = 1'b1;
          #1;
          check("abort_ready", in_ready, 0);
          check("abort_we", imem_we, 0);
          check("abort_addr", imem_addr, 0);
          check("abort_wdata", imem_wdata, 0);
          check("abort_hold", cpu_hold, 1);
          check("abort_done", load_done, 0);
          check("abort_err", load_error, 0);
          check("abort_wl", words_loaded, 0);
          check("abort_sb", sb.size(), 0);
          repeat (2) @(negedge clk);
          rst = 1'b0;
          sb.delete();
          return;
        end
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (x ^ 8'h01) : x);
`endif
    if (bad_csum) begin
      @(negedge clk);
      check("csum_err", load_error, 1);
      check("csum_hold", cpu_hold, 1);
      check("csum_ready", in_ready, 0);
      check("csum_done", load_done, 0);
    end else begin
      @(negedge clk);
      check("hold_finish", cpu_hold, 1);
      check("done_early", load_done, 0);
      check("ready_finish", in_ready, 0);
      @(negedge clk);
      check("hold_done", cpu_hold, 0);
      check("load_done", load_done, 1);
      check("load_err", load_error, 0);
      check("words_loaded", words_loaded, n);
      check("ready_done", in_ready, 0);
    end
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; start = 1'b0;
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_done", load_done, 0);
    check("rst_err", load_error, 0);
    check("rst_wl", words_loaded, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", in_ready, 1);

    // Two-word program, back-to-back bytes.
    wbuf[0] = 32'h00100513;
    wbuf[1] = 32'h00200593;
    load_words(2, -1, 0, 0, -1, 0);
    pulse_start();

    // Empty image.
    load_words(0, -1, 0, 0, -1, 0);
    pulse_start();

    // Oversized header: 5 words into a 4-word memory.
    send_byte(8'h05);
    send_byte(8'h00);
    @(negedge clk);
    check("err_flag", load_error, 1);
    check("err_hold", cpu_hold, 1);
    check("err_ready", in_ready, 0);
    check("err_done", load_done, 0);
    repeat (3) @(negedge clk);
    check("err_sticky", load_error, 1);
    pulse_start();

    // Exactly full memory.
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    load_words(4, -1, 0, 0, -1, 0);
    pulse_start();

    // Large count in the high byte (N=256) is also rejected.
    send_byte(8'h00);
    send_byte(8'h01);
    @(negedge clk);
    check("err_big", load_error, 1);
    pulse_start();

    // Stall between bytes 2 and 3, with an ignored start pulse in the gap.
    wbuf[0] = 32'hDDCCBBAA;
    load_words(1, 2, 3, 1, -1, 0);
    pulse_start();

    // Reset after 6 data bytes of a 2-word load, then a full reload.
    wbuf[0] = $urandom;
    wbuf[1] = $urandom;
    load_words(2, -1, 0, 0, 6, 0);
    @(negedge clk);
    check("post_abort_ready", in_ready, 1);
    load_words(2, -1, 0, 0, -1, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    wbuf[0] = 32'hDDCCBBAA;
    load_words(1, -1, 0, 0, -1, 0);
    pulse_start();
    load_words(1, -1, 0, 0, -1, 1);
    pulse_start();
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
